// File: rtl/step_position_tracker.sv
// +----------------------------------------------------------------------------+
// | step_position_tracker                                                      |
// | Per-axis signed step counter with synchronised STEP/DIR/ENABLE_N inputs,   |
// | per-channel preset and a coherent all-axis snapshot (valid/ack).           |
// | Optional soft-limit flags built only when STEP_POS_LIMIT_EN is defined.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module step_position_tracker #(
  parameter int CHANNELS    = 5,
  parameter int POS_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       step,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       enable_n,
  input  logic [CHANNELS-1:0]       set_pos,
  input  logic [CHANNELS*POS_W-1:0] set_value,
  output logic [CHANNELS*POS_W-1:0] pos,
  input  logic                      snap_req,
  output logic                      snap_valid,
  input  logic                      snap_ack,
  output logic [CHANNELS*POS_W-1:0] snap_pos,
  input  logic [CHANNELS*POS_W-1:0] lim_min,
  input  logic [CHANNELS*POS_W-1:0] lim_max,
  output logic [CHANNELS-1:0]       below_min,
  output logic [CHANNELS-1:0]       above_max
);

  localparam int             c_ARM_CNT = SYNC_STAGES + 1;
  localparam int             c_ARM_W   = $clog2(c_ARM_CNT + 1);
  localparam logic [POS_W-1:0] c_ONE   = POS_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } snap_state_t;

  logic [CHANNELS-1:0] r_step_sync [SYNC_STAGES];
  logic [CHANNELS-1:0] r_dir_sync  [SYNC_STAGES];
  logic [CHANNELS-1:0] r_en_n_sync [SYNC_STAGES];
  logic [CHANNELS-1:0] r_step_hist;
  logic [c_ARM_W-1:0]  r_arm_cnt;
  logic                w_armed;
  logic [CHANNELS-1:0] w_event;

  logic [POS_W-1:0]    r_pos      [CHANNELS];
  logic [POS_W-1:0]    r_snap_pos [CHANNELS];

  snap_state_t         r_state;
  snap_state_t         w_state_next;
  logic                w_snap_load;

  // dir/enable_n use the same depth as step so they stay cycle-aligned with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_step_sync[s] <= '0;
        r_dir_sync[s]  <= '0;
        r_en_n_sync[s] <= '0;
      end
      r_step_hist <= '0;
    end else begin
      r_step_sync[0] <= step;
      r_dir_sync[0]  <= dir;
      r_en_n_sync[0] <= enable_n;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_step_sync[s] <= r_step_sync[s-1];
        r_dir_sync[s]  <= r_dir_sync[s-1];
        r_en_n_sync[s] <= r_en_n_sync[s-1];
      end
      r_step_hist <= r_step_sync[SYNC_STAGES-1];
    end
  end

  // Holding off until the history flop has caught up means a STEP already
  // high at reset release never looks like a fresh rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + c_ARM_W'(1);
    end
  end

  assign w_armed = (r_arm_cnt == c_ARM_W'(c_ARM_CNT));
  assign w_event = r_step_sync[SYNC_STAGES-1] & ~r_step_hist & {CHANNELS{w_armed}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_pos[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (set_pos[c]) begin
          r_pos[c] <= set_value[c*POS_W +: POS_W];
        end else if (w_event[c] && !r_en_n_sync[SYNC_STAGES-1][c]) begin
          r_pos[c] <= r_dir_sync[SYNC_STAGES-1][c] ? (r_pos[c] - c_ONE)
                                                   : (r_pos[c] + c_ONE);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // An ack in HELD wins over a simultaneous req; that req is simply dropped.
  always_comb begin
    w_state_next = r_state;
    w_snap_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (snap_req) begin
          w_state_next = ST_HELD;
          w_snap_load  = 1'b1;
        end
      end
      ST_HELD: begin
        if (snap_ack) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_snap_pos[c] <= '0;
      end
    end else if (w_snap_load) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_snap_pos[c] <= r_pos[c];
      end
    end
  end

  assign snap_valid = (r_state == ST_HELD);

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_flat
      assign pos[g*POS_W +: POS_W]      = r_pos[g];
      assign snap_pos[g*POS_W +: POS_W] = r_snap_pos[g];
    end
  endgenerate

`ifdef STEP_POS_LIMIT_EN
  logic [CHANNELS-1:0] r_below_min;
  logic [CHANNELS-1:0] r_above_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_below_min <= '0;
      r_above_max <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_below_min[c] <= ($signed(r_pos[c]) < $signed(lim_min[c*POS_W +: POS_W]));
        r_above_max[c] <= ($signed(r_pos[c]) > $signed(lim_max[c*POS_W +: POS_W]));
      end
    end
  end

  assign below_min = r_below_min;
  assign above_max = r_above_max;
`else
  logic w_lim_unused;

  assign w_lim_unused = ^{lim_min, lim_max};
  assign below_min    = '0;
  assign above_max    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_step_position_tracker.sv
// +----------------------------------------------------------------------------+
// | tb_step_position_tracker                                                   |
// | Directed self-checking bench for step_position_tracker (default params).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_step_position_tracker;

  localparam int c_CH = 5;
  localparam int c_W  = 32;

  logic                clk;
  logic                reset;
  logic [c_CH-1:0]     step;
  logic [c_CH-1:0]     dir;
  logic [c_CH-1:0]     enable_n;
  logic [c_CH-1:0]     set_pos;
  logic [c_CH*c_W-1:0] set_value;
  logic [c_CH*c_W-1:0] pos;
  logic                snap_req;
  logic                snap_valid;
  logic                snap_ack;
  logic [c_CH*c_W-1:0] snap_pos;
  logic [c_CH*c_W-1:0] lim_min;
  logic [c_CH*c_W-1:0] lim_max;
  logic [c_CH-1:0]     below_min;
  logic [c_CH-1:0]     above_max;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef STEP_POS_LIMIT_EN
  localparam logic c_LIM = 1'b1;
`else
  localparam logic c_LIM = 1'b0;
`endif

  step_position_tracker #(
    .CHANNELS    (c_CH),
    .POS_W       (c_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .dir        (dir),
    .enable_n   (enable_n),
    .set_pos    (set_pos),
    .set_value  (set_value),
    .pos        (pos),
    .snap_req   (snap_req),
    .snap_valid (snap_valid),
    .snap_ack   (snap_ack),
    .snap_pos   (snap_pos),
    .lim_min    (lim_min),
    .lim_max    (lim_max),
    .below_min  (below_min),
    .above_max  (above_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pos_of(input int ch);
    return pos[ch*c_W +: c_W];
  endfunction

  function automatic logic [31:0] snap_of(input int ch);
    return snap_pos[ch*c_W +: c_W];
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int ch, input int n);
    for (int p = 0; p < n; p++) begin
      step[ch] = 1'b1;
      wait_n(3);
      step[ch] = 1'b0;
      wait_n(3);
    end
  endtask

  task automatic preset(input int ch, input logic [31:0] v);
    set_pos[ch]               = 1'b1;
    set_value[ch*c_W +: c_W]  = v;
    wait_n(1);
    set_pos[ch]               = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    step      = 5'b00001;
    dir       = '0;
    enable_n  = '0;
    set_pos   = '0;
    set_value = '0;
    snap_req  = 1'b0;
    snap_ack  = 1'b0;
    lim_min   = '0;
    lim_max   = '0;
    lim_min[0 +: c_W] = 32'hFFFF_FFFE;
    lim_max[0 +: c_W] = 32'd3;
    for (int c = 1; c < c_CH; c++) begin
      lim_min[c*c_W +: c_W] = 32'h8000_0000;
      lim_max[c*c_W +: c_W] = 32'h7FFF_FFFF;
    end

    wait_n(3);
    check_val("rst_pos",        {32'd0, pos[31:0] | pos[63:32] | pos[159:128]}, 64'd0);
    check_val("rst_snap_valid", {63'd0, snap_valid}, 64'd0);
    check_val("rst_snap_pos",   {32'd0, snap_of(0) | snap_of(4)}, 64'd0);
    check_val("rst_flags",      {54'd0, below_min, above_max}, 64'd0);

    // STEP already high at reset release must not count
    reset = 1'b0;
    wait_n(10);
    check_val("arm_held_high", pos_of(0), 32'd0);
    step[0] = 1'b0;
    wait_n(3);
    step[0] = 1'b1;
    wait_n(2);
    check_val("arm_latency_early", pos_of(0), 32'd0);
    wait_n(1);
    check_val("arm_latency_exact", pos_of(0), 32'd1);
    wait_n(2);
    step[0] = 1'b0;
    wait_n(3);

    // direction and enable on ch1
    pulse(1, 5);
    check_val("dir_up5", pos_of(1), 32'd5);
    dir[1] = 1'b1;
    pulse(1, 3);
    check_val("dir_down3", pos_of(1), 32'd2);
    dir[1] = 1'b0;
    enable_n[1] = 1'b1;
    pulse(1, 4);
    check_val("enable_n_ignored", pos_of(1), 32'd2);
    enable_n[1] = 1'b0;
    check_val("other_ch0", pos_of(0), 32'd1);
    check_val("other_ch2_4", {32'd0, pos_of(2) | pos_of(3) | pos_of(4)}, 64'd0);

    // wrap on ch2
    preset(2, 32'h7FFF_FFFF);
    check_val("preset_latency", pos_of(2), 32'h7FFF_FFFF);
    pulse(2, 1);
    check_val("wrap_up", pos_of(2), 32'h8000_0000);
    dir[2] = 1'b1;
    pulse(2, 1);
    check_val("wrap_down", pos_of(2), 32'h7FFF_FFFF);
    dir[2] = 1'b0;

    // preset in the same cycle as a step event on ch3
    step[3] = 1'b1;
    wait_n(2);
    preset(3, 32'd100);
    check_val("preset_priority", pos_of(3), 32'd100);
    wait_n(3);
    check_val("preset_step_discarded", pos_of(3), 32'd100);
    step[3] = 1'b0;
    wait_n(3);
    pulse(3, 1);
    check_val("after_preset_step", pos_of(3), 32'd101);

    // snapshot: capture is pos before the same-cycle preset of ch0
    set_pos = '1;
    for (int c = 0; c < c_CH; c++) set_value[c*c_W +: c_W] = 32'(10 * (c + 1));
    wait_n(1);
    set_pos = 5'b00001;
    set_value[0 +: c_W] = 32'd99;
    snap_req = 1'b1;
    wait_n(1);
    set_pos  = '0;
    snap_req = 1'b0;
    check_val("snap_valid_set", {63'd0, snap_valid}, 64'd1);
    for (int c = 0; c < c_CH; c++) check_val($sformatf("snap_pos%0d", c), snap_of(c), 32'(10 * (c + 1)));
    check_val("pos0_after_snap_preset", pos_of(0), 32'd99);
    pulse(1, 1);
    snap_req = 1'b1;
    wait_n(1);
    snap_req = 1'b0;
    check_val("snap_frozen_ch1", snap_of(1), 32'd20);
    check_val("live_ch1", pos_of(1), 32'd21);
    check_val("snap_still_valid", {63'd0, snap_valid}, 64'd1);
    snap_req = 1'b1;
    snap_ack = 1'b1;
    wait_n(1);
    snap_req = 1'b0;
    snap_ack = 1'b0;
    check_val("ack_wins", {63'd0, snap_valid}, 64'd0);
    wait_n(1);
    check_val("req_dropped", {63'd0, snap_valid}, 64'd0);
    snap_req = 1'b1;
    wait_n(1);
    snap_req = 1'b0;
    check_val("resnap_ch1", snap_of(1), 32'd21);
    check_val("resnap_ch0", snap_of(0), 32'd99);
    snap_ack = 1'b1;
    wait_n(1);
    snap_ack = 1'b0;
    check_val("ack_clears", {63'd0, snap_valid}, 64'd0);

    // soft limits on ch0 (min -2, max 3); flags lag pos by one clock
    preset(0, 32'd3);
    wait_n(1);
    check_val("lim_at_max", {62'd0, below_min[0], above_max[0]}, 64'd0);
    step[0] = 1'b1;
    wait_n(3);
    check_val("lim_pos4", pos_of(0), 32'd4);
    check_val("lim_above_lag", {63'd0, above_max[0]}, 64'd0);
    wait_n(1);
    check_val("lim_above", {63'd0, above_max[0]}, {63'd0, c_LIM});
    wait_n(1);
    step[0] = 1'b0;
    wait_n(3);
    preset(0, 32'hFFFF_FFFD);
    check_val("lim_below_lag", {62'd0, below_min[0], above_max[0]}, {62'd0, 1'b0, c_LIM});
    wait_n(1);
    check_val("lim_below", {62'd0, below_min[0], above_max[0]}, {62'd0, c_LIM, 1'b0});
    check_val("lim_other_ch", {56'd0, below_min[4:1], above_max[4:1]}, 64'd0);

    // asynchronous reset in the middle of a held snapshot
    snap_req = 1'b1;
    wait_n(1);
    snap_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_val("areset_pos", {32'd0, pos_of(0) | pos_of(1) | pos_of(2) | pos_of(3) | pos_of(4)}, 64'd0);
    check_val("areset_snap", {31'd0, snap_valid, snap_of(0) | snap_of(1) | snap_of(3)}, 64'd0);
    check_val("areset_flags", {54'd0, below_min, above_max}, 64'd0);
    wait_n(2);
    reset = 1'b0;
    wait_n(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/step_position_tracker.md
# step_position_tracker

Parametrised, clocked successor to the printer's per-axis step position counter. It tracks CHANNELS stepper axes (X, Y, Z, E0, E1 by default) by counting synchronised STEP rising edges signed by DIR and gated by active-low ENABLE. It supports per-channel coordinate preset and a coherent all-axis snapshot with a valid/ack handshake for the host-readout path. Sits between the motion generator/driver outputs and the register interface.

## Interface
- CHANNELS, 5, number of tracked axes (1..16); channel i occupies bits [i*POS_W +: POS_W] of flat buses
- POS_W, 32, signed position width, two's complement
- SYNC_STAGES, 2, synchroniser depth on step/dir/enable_n (min 2)

- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- step  in  CHANNELS  driver STEP lines, asynchronous to clk
- dir  in  CHANNELS  0 = +1, 1 = -1
- enable_n  in  CHANNELS  0 = driver enabled (steps counted), 1 = steps ignored
- set_pos  in  CHANNELS  clk-synchronous one-cycle preset strobe per channel
- set_value  in  CHANNELS*POS_W  preset values
- pos  out  CHANNELS*POS_W  live positions
- snap_req  in  1  one-cycle snapshot request
- snap_valid  out  1  snapshot held and valid
- snap_ack  in  1  consumer has read snapshot
- snap_pos  out  CHANNELS*POS_W  frozen positions
- lim_min, lim_max  in  CHANNELS*POS_W each  soft limits (used only with STEP_POS_LIMIT_EN)
- below_min, above_max  out  CHANNELS each  soft-limit flags

## Operation
- Reset values: pos = 0, snap_pos = 0, snap_valid = 0, below_min = above_max = 0, all synchroniser/history flops = 0, arm counter = 0.
- step, dir and enable_n each pass through SYNC_STAGES flops; dir/enable_n stay aligned with step.
- Step event on channel i: synchronised step = 1, history flop = 0, channel armed.
- Arming: after reset deassertion, events are suppressed for SYNC_STAGES+1 clocks. A STEP already high at release is never counted.
- On an event: if enable_n_sync = 0, pos += (dir_sync ? -1 : +1); otherwise no change. Arithmetic wraps modulo 2^POS_W: max positive +1 gives min negative, and vice versa.
- set_pos[i] = 1: pos_i <= set_value_i at the next edge. This takes priority over a simultaneous step event on that channel, and the step is discarded. Other channels are unaffected.
- Snapshot FSM, IDLE/HELD:
  - IDLE + snap_req: snap_pos <= pos, all channels from the same cycle; the value captured is pos before this cycle's updates. Go to HELD, snap_valid = 1.
  - HELD: snap_pos is frozen. snap_req is ignored. snap_ack returns to IDLE and snap_valid = 0 next cycle.
  - snap_req and snap_ack in the same HELD cycle: the ack is honoured and the req is dropped.
- Reset mid-operation clears everything immediately (asynchronous), including HELD state.

## Timing
- STEP first sampled high at edge k: pos updates at edge k+SYNC_STAGES.
- Minimum STEP high and low time is 2 clk periods each. Faster pulses may be lost; this is not detected.
- set_pos: latency 1 clock.
- snap_req at edge k: snap_valid and snap_pos change at edge k.
- Limit flags (when enabled) are registered, 1 clock after pos.

## Configuration
- STEP_POS_LIMIT_EN defined:
  - below_min_i = (pos_i < lim_min_i), signed compare, registered.
  - above_max_i = (pos_i > lim_max_i), signed compare, registered.
  - Flags are status only and never block counting.
- Undefined: comparators are not built, the flags are tied to 0, and lim_min/lim_max are ignored. Ports are always present.

## Test plan
- Arming: reset released with step[0]=1 and enable_n=0, then held 10 clocks → pos0 stays 0. Next full low/high pulse → pos0 = 1 exactly SYNC_STAGES clocks after the high is sampled.
- Direction/enable: ch1 gets 5 pulses with dir=0, then 3 with dir=1, then 4 with enable_n=1 → pos1 = 2. All other channels stay 0.
- Wrap: set_pos[2] with set_value = 0x7FFFFFFF, then one +1 step → pos2 = 0x80000000. Then one -1 step → 0x7FFFFFFF.
- Preset priority: set_pos[3] with value 100, asserted in the same cycle as a step event (+1) on ch3 → pos3 = 100. Next step → 101.
- Snapshot: pos = {10,20,30,40,50}, snap_req → snap_valid = 1 and snap_pos = {10,20,30,40,50}. Steps continue and a second snap_req is issued → snap_pos unchanged. snap_ack → snap_valid = 0 next clock.
- Limits (macro on): lim_min0 = -2, lim_max0 = 3. Step ch0 to 4 → above_max0 = 1 one clock later. Preset to -3 → below_min0 = 1 and above_max0 = 0. Asynchronous reset mid-run → all outputs 0 immediately.
